// File: rtl/fp16add_arb.sv
`default_nettype none
// ============================================================================
// Module      : fp16add_arb
// Description : Round-robin arbiter that shares a single fp16 add pipeline
//               between N requesters. The granted operands are registered
//               into the adder. A one-hot requester tag travels alongside
//               each operation, so every sum is returned to the requester
//               that issued it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N    : number of requesters (2..8)
//   LAT  : adder latency in cycles, o_add_valid -> i_add_res valid (0..8)
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   i_en         in   1      1 = new grants allowed; the pipe always drains
//   i_req_valid  in   N      per-requester operand valid
//   o_req_ready  out  N      one-hot grant (transfer on valid & ready)
//   i_req_a      in   16*N   operand A, requester k at [16k+15:16k]
//   i_req_b      in   16*N   operand B, same packing
//   o_add_a      out  16     registered operand A to the adder
//   o_add_b      out  16     registered operand B to the adder
//   o_add_valid  out  1      o_add_a/o_add_b hold an issued operation
//   i_add_res    in   16     adder result, valid LAT cycles after o_add_valid
//   o_rsp_valid  out  N      one-hot 1-cycle pulse marking the result owner
//   o_rsp_res    out  16     registered sum
// Optional build macro
//   FP16ADD_ARB_CNT_EN : adds i_cnt_clr (in, 1) and o_issue_cnt (out, 16*N),
//                        which are saturating per-requester grant counters.
// ============================================================================
module fp16add_arb #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic [N-1:0]    i_req_valid,
  output logic [N-1:0]    o_req_ready,
  input  logic [16*N-1:0] i_req_a,
  input  logic [16*N-1:0] i_req_b,
  output logic [15:0]     o_add_a,
  output logic [15:0]     o_add_b,
  output logic            o_add_valid,
  input  logic [15:0]     i_add_res,
  output logic [N-1:0]    o_rsp_valid,
  output logic [15:0]     o_rsp_res
`ifdef FP16ADD_ARB_CNT_EN
  ,
  input  logic            i_cnt_clr,
  output logic [16*N-1:0] o_issue_cnt
`endif
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Round-robin pointer: index of the most recently granted requester.
  logic [IDX_W-1:0]    rr;
  logic [N-1:0]        grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand;
  logic [15:0]         sel_a;
  logic [15:0]         sel_b;

  // Stage 0 is the tag of the operation now on o_add_a/o_add_b. Stage LAT
  // lines up with i_add_res.
  logic [LAT:0][N-1:0] tag_pipe;

  // --------------------------------------------------------------------------
  // Arbitration. The candidates are visited from the farthest offset (rr+N)
  // down to the nearest (rr+1). The last match overwrites earlier ones, so the
  // nearest valid requester after rr wins without a separate "found" chain.
  // --------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    if (i_en) begin
      for (int off = N; off >= 1; off--) begin
        cand = IDX_W'((int'(rr) + off) % N);
        if (i_req_valid[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign o_req_ready = grant;
  assign sel_a       = i_req_a[16*grant_idx +: 16];
  assign sel_b       = i_req_b[16*grant_idx +: 16];

  // --------------------------------------------------------------------------
  // Issue register, tag pipe and response capture. The tag pipe has no stall,
  // which matches the fixed-latency adder behind o_add_a/o_add_b.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr          <= IDX_W'(N - 1);
      o_add_a     <= '0;
      o_add_b     <= '0;
      o_add_valid <= 1'b0;
      tag_pipe    <= '0;
      o_rsp_valid <= '0;
      o_rsp_res   <= '0;
    end else begin
      if (|grant) begin
        rr      <= grant_idx;
        o_add_a <= sel_a;
        o_add_b <= sel_b;
      end
      o_add_valid <= |grant;
      tag_pipe[0] <= grant;
      for (int s = 1; s <= LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      o_rsp_valid <= tag_pipe[LAT];
      // The result is held between responses so that o_rsp_res stays stable.
      if (|tag_pipe[LAT]) begin
        o_rsp_res <= i_add_res;
      end
    end
  end

`ifdef FP16ADD_ARB_CNT_EN
  // --------------------------------------------------------------------------
  // Per-requester grant counters. A clear beats a same-cycle increment, and
  // each counter sticks at all-ones.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_cnt
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (i_cnt_clr) begin
        cnt <= '0;
      end else if (grant[k] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end

    assign o_issue_cnt[16*k +: 16] = cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16add_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16add_arb
// Description : Directed testbench for fp16add_arb with N=4 and LAT=2. The
//               adder behind the arbiter is modelled as an fp16 add followed
//               by two register stages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16add_arb;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [15:0]     add_a;
  logic [15:0]     add_b;
  logic            add_valid;
  logic [15:0]     add_res;
  logic [N-1:0]    rsp_valid;
  logic [15:0]     rsp_res;
`ifdef FP16ADD_ARB_CNT_EN
  logic            cnt_clr;
  logic [16*N-1:0] issue_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] rr_exp [4];

  always #5 clk = ~clk;

  fp16add_arb #(.N(N), .LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (en),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_valid (add_valid),
    .i_add_res   (add_res),
    .o_rsp_valid (rsp_valid),
    .o_rsp_res   (rsp_res)
`ifdef FP16ADD_ARB_CNT_EN
    ,
    .i_cnt_clr   (cnt_clr),
    .o_issue_cnt (issue_cnt)
`endif
  );

  // fp16 add with DAZ/FTZ. The sum is formed exactly and then truncated, which
  // is exact for every vector used here.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    int          ea, eb, elo, lead, er;
    longint      ma, mb, sum;
    logic [63:0] mag;
    logic [63:0] mant;
    logic        sgn;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 64'sd0 : longint'({1'b1, a[9:0]});
    mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[9:0]});
    if (ma == 0) ea = eb;
    if (mb == 0) eb = ea;
    if (a[15]) ma = -ma;
    if (b[15]) mb = -mb;
    elo = (ea < eb) ? ea : eb;
    sum = (ma <<< (ea - elo)) + (mb <<< (eb - elo));
    sgn = (sum < 0);
    mag = sgn ? 64'(-sum) : 64'(sum);
    if (mag == 0) return 16'h0000;
    lead = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) lead = i;
    er   = elo + lead - 10;
    mant = (lead >= 10) ? (mag >> (lead - 10)) : (mag << (10 - lead));
    if (er <= 0)  return {sgn, 15'h0000};
    if (er >= 31) return {sgn, 5'h1F, 10'h000};
    return {sgn, 5'(er), mant[9:0]};
  endfunction

  // Adder model: the add registered twice, giving LAT=2.
  logic [15:0] add_s1, add_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_s1 <= '0;
      add_s2 <= '0;
    end else begin
      add_s1 <= fp16_add(add_a, add_b);
      add_s2 <= add_s1;
    end
  end
  assign add_res = add_s2;

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[16*k +: 16] = a;
    req_b[16*k +: 16] = b;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
`ifdef FP16ADD_ARB_CNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (add_valid !== 1'b0) $display("FAIL reset_add_valid: got %b want 0", add_valid); else n_pass++;
    n_total++; if ({add_a, add_b} !== 32'h0) $display("FAIL reset_add_ops: got %h want 0", {add_a, add_b}); else n_pass++;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
    n_total++; if (rsp_res !== 16'h0000) $display("FAIL reset_rsp_res: got %h want 0000", rsp_res); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_idle: got %b want 0000", req_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_op(1, 16'h3C00, 16'h4000);
    req_valid = 4'b0010;
    #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_total++; if (add_valid !== 1'b1) $display("FAIL single_add_valid: got %b want 1", add_valid); else n_pass++;
    n_total++; if ({add_a, add_b} !== {16'h3C00, 16'h4000}) $display("FAIL single_add_ops: got %h want 3c004000", {add_a, add_b}); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_early: got %b want 0000", rsp_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 4'b0010) $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); else n_pass++;
    n_total++; if (rsp_res !== 16'h4200) $display("FAIL single_rsp_res: got %h want 4200", rsp_res); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_pulse: got %b want 0000", rsp_valid); else n_pass++;
    n_total++; if (rsp_res !== 16'h4200) $display("FAIL single_rsp_hold: got %h want 4200", rsp_res); else n_pass++;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_op(0, 16'h3C00, 16'h3C00);  // 1+1 = 2
    set_op(1, 16'h3C00, 16'h4000);  // 1+2 = 3
    set_op(2, 16'h3C00, 16'h4200);  // 1+3 = 4
    set_op(3, 16'h3C00, 16'h4400);  // 1+4 = 5
    rr_exp[0] = 16'h4000;
    rr_exp[1] = 16'h4200;
    rr_exp[2] = 16'h4400;
    rr_exp[3] = 16'h4500;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = (i < 8) ? 4'hF : 4'h0;
      #1;
      if (i < 8) begin
        n_total++; if (req_ready !== (4'b0001 << (i % 4))) $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, 4'b0001 << (i % 4)); else n_pass++;
      end
      if (i < 4) begin
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL rr_rsp_idle[%0d]: got %b want 0000", i, rsp_valid); else n_pass++;
      end else begin
        n_total++; if (rsp_valid !== (4'b0001 << ((i - 4) % 4))) $display("FAIL rr_rsp_tag[%0d]: got %b want %b", i, rsp_valid, 4'b0001 << ((i - 4) % 4)); else n_pass++;
        n_total++; if (rsp_res !== rr_exp[(i - 4) % 4]) $display("FAIL rr_rsp_res[%0d]: got %h want %h", i, rsp_res, rr_exp[(i - 4) % 4]); else n_pass++;
      end
    end
  endtask

  task automatic test_skip();
    // Pointer is at 3, so port 0 goes first, then 2 is reached by skipping 1.
    set_op(0, 16'h3E00, 16'h3C00);  // 1.5+1 = 2.5
    set_op(2, 16'h4000, 16'h4000);  // 2+2 = 4
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL skip_grant0: got %b want 0001", req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL skip_grant1: got %b want 0100", req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL skip_grant2: got %b want 0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    n_total++; if ({rsp_valid, rsp_res} !== {4'b0001, 16'h4100}) $display("FAIL skip_rsp0: got %b/%h want 0001/4100", rsp_valid, rsp_res); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if ({rsp_valid, rsp_res} !== {4'b0100, 16'h4400}) $display("FAIL skip_rsp1: got %b/%h want 0100/4400", rsp_valid, rsp_res); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if ({rsp_valid, rsp_res} !== {4'b0001, 16'h4100}) $display("FAIL skip_rsp2: got %b/%h want 0001/4100", rsp_valid, rsp_res); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL skip_rsp_end: got %b want 0000", rsp_valid); else n_pass++;
  endtask

  task automatic test_enable();
    // Pointer is at 0 here.
    set_op(0, 16'h3C00, 16'h3C00);
    set_op(1, 16'h3C00, 16'h4000);
    set_op(2, 16'h3C00, 16'h4200);
    set_op(3, 16'h3C00, 16'h4400);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL en_first_grant: got %b want 0010", req_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en        = 1'b0;
      req_valid = 4'hF;
      #1;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL en_off_ready[%0d]: got %b want 0000", i, req_ready); else n_pass++;
      if (i > 0) begin
        n_total++; if (add_valid !== 1'b0) $display("FAIL en_off_add_valid[%0d]: got %b want 0", i, add_valid); else n_pass++;
      end
    end
    @(negedge clk);
    en = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL en_resume_grant: got %b want 0100", req_ready); else n_pass++;
    n_total++; if ({rsp_valid, rsp_res} !== {4'b0010, 16'h4200}) $display("FAIL en_inflight_rsp: got %b/%h want 0010/4200", rsp_valid, rsp_res); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (req_ready !== 4'b1000) $display("FAIL en_next_grant: got %b want 1000", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL en_rsp_gap: got %b want 0000", rsp_valid); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if ({rsp_valid, rsp_res} !== {4'b0100, 16'h4400}) $display("FAIL en_rsp2: got %b/%h want 0100/4400", rsp_valid, rsp_res); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if ({rsp_valid, rsp_res} !== {4'b1000, 16'h4500}) $display("FAIL en_rsp3: got %b/%h want 1000/4500", rsp_valid, rsp_res); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    // Pointer is at 3: port 1 is granted first, then port 2.
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL mid_grant0: got %b want 0010", req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL mid_grant1: got %b want 0100", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    n_total++; if (add_valid !== 1'b0) $display("FAIL mid_rst_add_valid: got %b want 0", add_valid); else n_pass++;
    n_total++; if ({add_a, add_b} !== 32'h0) $display("FAIL mid_rst_add_ops: got %h want 0", {add_a, add_b}); else n_pass++;
    n_total++; if ({rsp_valid, rsp_res} !== 20'h0) $display("FAIL mid_rst_rsp: got %b/%h want 0000/0000", rsp_valid, rsp_res); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_no_rsp[%0d]: got %b want 0000", i, rsp_valid); else n_pass++;
      @(negedge clk);
    end
    req_valid = 4'hF;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

`ifdef FP16ADD_ARB_CNT_EN
  task automatic test_counters();
    @(negedge clk);
    cnt_clr   = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    cnt_clr   = 1'b0;
    req_valid = 4'b1000;
    repeat (5) @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_total++; if (issue_cnt[63:48] !== 16'd5) $display("FAIL cnt_five: got %h want 0005", issue_cnt[63:48]); else n_pass++;
    n_total++; if (issue_cnt[47:0] !== 48'h0) $display("FAIL cnt_others: got %h want 0", issue_cnt[47:0]); else n_pass++;
    @(negedge clk);
    cnt_clr   = 1'b1;
    req_valid = 4'b1000;
    @(negedge clk);
    cnt_clr   = 1'b0;
    req_valid = 4'b0000;
    #1;
    n_total++; if (issue_cnt[63:48] !== 16'd0) $display("FAIL cnt_clr_prio: got %h want 0000", issue_cnt[63:48]); else n_pass++;
    @(negedge clk);
    req_valid = 4'b1000;
    repeat (65535) @(negedge clk);
    #1;
    n_total++; if (issue_cnt[63:48] !== 16'hFFFF) $display("FAIL cnt_full: got %h want ffff", issue_cnt[63:48]); else n_pass++;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_total++; if (issue_cnt[63:48] !== 16'hFFFF) $display("FAIL cnt_saturate: got %h want ffff", issue_cnt[63:48]); else n_pass++;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_enable();
    test_reset_midflight();
`ifdef FP16ADD_ARB_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
